// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NUM_REQ byte producers.
// The channel stays locked to one producer until it sends the byte flagged last.
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int IDX_W         = 2,
  parameter int START_TIMEOUT = 15
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [8*NUM_REQ-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]   req_last_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic [7:0]           tx_data_o,
  output logic                 tx_trigger_o,
  input  logic                 tx_complete_i,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic                 busy_o,
  output logic                 err_o
);

  localparam int CNT_W = $clog2(START_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(START_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(START_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    TRIG       = 2'd1,
    WAIT_START = 2'd2,
    WAIT_DONE  = 2'd3
  } state_t;

  state_t             state;
  state_t             state_next;

  logic               locked;
  logic               last_byte;
  logic [IDX_W-1:0]   owner;
  logic [IDX_W-1:0]   ptr;
  logic [CNT_W-1:0]   cnt;

  logic [IDX_W-1:0]   cand;
  logic [IDX_W-1:0]   idx;
  logic               cand_valid;
  logic [NUM_REQ-1:0] cand_onehot;
  logic               accept;
  logic               timeout;
  logic               byte_done;

  logic [7:0]         req_bytes [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign req_bytes[k] = req_data_i[8*k +: 8];
  end

  // Locked: only the owner may send. Unlocked: first valid requester at or above ptr, wrapping.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    cand       = ptr;
    idx        = '0;
    cand_valid = 1'b0;
    if (locked) begin
      cand       = owner;
      cand_valid = req_valid_i[owner];
    end else begin
      // Walk offsets from farthest to nearest so the nearest valid requester wins.
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        idx = IDX_W'((int'(ptr) + i) % NUM_REQ);
        if (req_valid_i[idx]) begin
          cand       = idx;
          cand_valid = 1'b1;
        end
      end
    end
  end

  assign cand_onehot = NUM_REQ'(1) << cand;
  assign accept      = (state == IDLE) && tx_complete_i && cand_valid && !rst_i;
  assign timeout     = (state == WAIT_START) && tx_complete_i && (cnt == CNT_LAST);
  assign byte_done   = ((state == WAIT_DONE) && tx_complete_i) || timeout;

  // State register
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:       if (accept) state_next = TRIG;
      TRIG:       state_next = WAIT_START;
      WAIT_START: begin
        if (!tx_complete_i) state_next = WAIT_DONE;
        else if (timeout)   state_next = IDLE;
      end
      WAIT_DONE:  if (tx_complete_i) state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    tx_trigger_o = (state == TRIG);
    busy_o       = (state != IDLE);
    req_ready_o  = accept ? cand_onehot : '0;
  end

  // Datapath: captured byte, ownership, round-robin pointer, start-timeout counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_data_o <= '0;
      grant_o   <= '0;
      owner     <= '0;
      ptr       <= '0;
      locked    <= 1'b0;
      last_byte <= 1'b0;
      cnt       <= '0;
      err_o     <= 1'b0;
    end else begin
      if (accept) begin
        tx_data_o <= req_bytes[cand];
        grant_o   <= cand_onehot;
        owner     <= cand;
        locked    <= 1'b1;
        last_byte <= req_last_i[cand];
      end

      if (state == TRIG)
        cnt <= '0;
      else if ((state == WAIT_START) && (cnt != CNT_MAX))
        cnt <= cnt + 1'b1;

      if (timeout)
        err_o <= 1'b1;

      // A timed-out byte is retired exactly like a completed one.
      if (byte_done && last_byte) begin
        locked  <= 1'b0;
        grant_o <= '0;
        ptr     <= (owner == IDX_TOP) ? '0 : owner + 1'b1;
      end
    end
  end

endmodule
